// File: rtl/core_prefetch_unit_pkg.sv
// Shared defaults and issue-FSM encoding for the RV32I decoupled instruction prefetcher.
package core_prefetch_unit_pkg;

  localparam int          FETCH_DEPTH           = 4;
  localparam int          FETCH_MAX_OUTSTANDING = 2;
  localparam logic [31:0] FETCH_RESET_PC        = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } issue_state_t;

endpackage

// File: rtl/core_fetch_fifo.sv
// DEPTH-entry synchronous FIFO (word + address), push/pop/flush; head visible combinationally from registers.
module core_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_dat,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_dat;
        r_wr        <= r_wr + PW'(1);
      end
      if (i_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_dat   = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/core_prefetch_unit.sv
// Decoupled instruction prefetcher: credit-limited pipelined req/gnt/rvalid fetch into a FIFO, branch redirect with stale-response discard.
// Optional PREFETCH_BYPASS_EN: an accepted response into an empty FIFO is presented to decode in the same cycle.
module core_prefetch_unit
  import core_prefetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    MEM_ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DEPTH           = FETCH_DEPTH,
  parameter int                    MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      branch_i,
  input  logic [ADDR_WIDTH-1:0]     branch_addr_i,
  input  logic                      fetch_ready_i,
  output logic                      fetch_valid_o,
  output logic [DATA_WIDTH-1:0]     fetch_instr_o,
  output logic [ADDR_WIDTH-1:0]     fetch_addr_o,
  output logic                      req_mem_prog_o,
  output logic [MEM_ADDR_WIDTH-1:0] addr_mem_prog_o,
  input  logic                      gnt_mem_prog_i,
  input  logic                      rvalid_mem_prog_i,
  input  logic [DATA_WIDTH-1:0]     val_mem_prog_i
);

  localparam int                    CW         = $clog2(DEPTH + 1);
  localparam int                    CW1        = CW + 1;
  localparam int                    EW         = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  issue_state_t          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_redir_addr, w_redir_addr_nxt;
  logic                  r_redir_vld, w_redir_vld_nxt;
  logic [ADDR_WIDTH-1:0] r_resp_addr, w_resp_addr_nxt;
  logic [CW-1:0]         r_outstanding, w_out_nxt;
  logic [CW-1:0]         r_discard, w_disc_nxt;
  logic [CW-1:0]         w_count, w_count_nxt;
  logic                  w_full, w_empty, w_push, w_pop;
  logic                  w_gnt, w_rsp, w_accept, w_hold, w_credit;
  logic [EW-1:0]         w_head;
  logic [ADDR_WIDTH-1:0] w_target;

  assign w_target = branch_addr_i & ALIGN_MASK;
  assign w_gnt    = (r_state == ST_REQ) && gnt_mem_prog_i;
  assign w_hold   = (r_state == ST_REQ) && !gnt_mem_prog_i;
  assign w_rsp    = rvalid_mem_prog_i && (r_outstanding != '0);
  assign w_accept = w_rsp && (r_discard == '0) && !branch_i;
  assign w_pop    = !w_empty && fetch_ready_i && !branch_i;

`ifdef PREFETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass      = w_empty && w_accept;
  assign fetch_valid_o = !w_empty || w_bypass;
  assign fetch_instr_o = !w_empty ? w_head[DATA_WIDTH-1:0] : (w_bypass ? val_mem_prog_i : '0);
  assign fetch_addr_o  = !w_empty ? w_head[EW-1:DATA_WIDTH] : r_resp_addr;
  assign w_push        = w_accept && !(w_bypass && fetch_ready_i) && (!w_full || w_pop);
`else
  assign fetch_valid_o = !w_empty;
  assign fetch_instr_o = !w_empty ? w_head[DATA_WIDTH-1:0] : '0;
  assign fetch_addr_o  = !w_empty ? w_head[EW-1:DATA_WIDTH] : r_resp_addr;
  assign w_push        = w_accept && (!w_full || w_pop);
`endif

  core_fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   ({r_resp_addr, val_mem_prog_i}),
    .i_pop   (w_pop),
    .i_flush (branch_i),
    .o_dat   (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_redir_vld_nxt  = r_redir_vld;
    w_redir_addr_nxt = r_redir_addr;
    w_resp_addr_nxt  = r_resp_addr;
    w_disc_nxt       = r_discard;
    w_out_nxt        = r_outstanding + CW'(w_gnt) - CW'(w_rsp);
    w_count_nxt      = branch_i ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    w_credit         = (w_out_nxt < CW'(MAX_OUTSTANDING)) &&
                       (({1'b0, w_count_nxt} + {1'b0, w_out_nxt}) < CW1'(DEPTH));

    if (branch_i) begin
      // Everything in flight is stale, including an ungranted request that must still complete.
      w_resp_addr_nxt = w_target;
      w_disc_nxt      = w_out_nxt + CW'(w_hold);
      if (w_hold) begin
        w_redir_vld_nxt  = 1'b1;
        w_redir_addr_nxt = w_target;
      end else begin
        w_pc_nxt        = w_target;
        w_redir_vld_nxt = 1'b0;
      end
    end else begin
      if (w_accept) w_resp_addr_nxt = r_resp_addr + ADDR_WIDTH'(4);
      if (w_rsp && (r_discard != '0)) w_disc_nxt = r_discard - CW'(1);
      if (w_gnt) begin
        if (r_redir_vld) begin
          w_pc_nxt        = r_redir_addr;
          w_redir_vld_nxt = 1'b0;
        end else begin
          w_pc_nxt = r_pc + ADDR_WIDTH'(4);
        end
      end
    end

    case (r_state)
      ST_IDLE: if (w_credit) w_state_nxt = ST_REQ;
      ST_REQ:  if (w_gnt && !w_credit) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_redir_vld   <= 1'b0;
      r_redir_addr  <= RESET_PC;
      r_resp_addr   <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_redir_vld   <= w_redir_vld_nxt;
      r_redir_addr  <= w_redir_addr_nxt;
      r_resp_addr   <= w_resp_addr_nxt;
      r_outstanding <= w_out_nxt;
      r_discard     <= w_disc_nxt;
    end
  end

  assign req_mem_prog_o  = (r_state == ST_REQ);
  assign addr_mem_prog_o = r_pc[MEM_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_core_prefetch_unit.sv
// Randomized bench for core_prefetch_unit: bus-level memory model plus an in-order fetch-stream scoreboard.
module tb_core_prefetch_unit;

  localparam int MAXO = 2;
  localparam int DEP  = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_ready_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_addr_o;
  logic        req_mem_prog_o;
  logic [9:0]  addr_mem_prog_o;
  logic        gnt_mem_prog_i;
  logic        rvalid_mem_prog_i;
  logic [31:0] val_mem_prog_i;

  core_prefetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .branch_i          (branch_i),
    .branch_addr_i     (branch_addr_i),
    .fetch_ready_i     (fetch_ready_i),
    .fetch_valid_o     (fetch_valid_o),
    .fetch_instr_o     (fetch_instr_o),
    .fetch_addr_o      (fetch_addr_o),
    .req_mem_prog_o    (req_mem_prog_o),
    .addr_mem_prog_o   (addr_mem_prog_o),
    .gnt_mem_prog_i    (gnt_mem_prog_i),
    .rvalid_mem_prog_i (rvalid_mem_prog_i),
    .val_mem_prog_i    (val_mem_prog_i)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          gnt_pct, rv_pct, rdy_pct;
  bit          br_now, inj_rv, want_first, saw_wrap;
  logic [31:0] br_target;
  logic [9:0]  mq[$];
  logic [31:0] exp_addr, first_after_br, prev_pop_addr;
  bit          prev_hold, prev_stall, prev_branch;
  logic [9:0]  prev_req_addr;
  logic [31:0] prev_faddr, prev_finstr;
  int          pops, rvs, first_rv, first_v, gap;

  function automatic logic [31:0] memfn(input logic [9:0] a);
    return 32'h5A00_0001 ^ {12'h0, a, 10'h0} ^ {22'h0, a};
  endfunction

  task automatic clear_model();
    mq.delete();
    exp_addr = 32'h0; prev_pop_addr = 32'h1;
    prev_hold = 0; prev_stall = 0; prev_branch = 0;
    first_rv = -1; first_v = -1; gap = 0; rvs = 0; pops = 0;
    want_first = 0; saw_wrap = 0; br_now = 0; inj_rv = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_i = 0; branch_addr_i = 0; fetch_ready_i = 0;
    gnt_mem_prog_i = 0; rvalid_mem_prog_i = 0; val_mem_prog_i = 0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One bus cycle: drive at negedge, sample 1ns later, update the reference stream.
  task automatic tick();
    logic [9:0] a;
    @(negedge clk);
    rvalid_mem_prog_i = 1'b0;
    val_mem_prog_i    = 32'h0;
    if (inj_rv) begin
      rvalid_mem_prog_i = 1'b1;
      val_mem_prog_i    = 32'hDEAD_BEEF;
      inj_rv            = 0;
    end else if (mq.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
      a = mq.pop_front();
      rvalid_mem_prog_i = 1'b1;
      val_mem_prog_i    = memfn(a);
    end
    gnt_mem_prog_i = int'($urandom_range(99)) < gnt_pct;
    fetch_ready_i  = int'($urandom_range(99)) < rdy_pct;
    branch_i       = br_now;
    branch_addr_i  = br_target;
    br_now         = 0;
    #1;
    cyc++;
    if (rvalid_mem_prog_i && first_rv < 0) first_rv = cyc;
    if (fetch_valid_o && first_v < 0) first_v = cyc;
    if (first_v >= 0 && !fetch_valid_o) gap++;
    if (rvalid_mem_prog_i) rvs++;
    if (prev_hold) begin
      checks++;
      if (req_mem_prog_o !== 1'b1 || addr_mem_prog_o !== prev_req_addr) begin
        failures++;
        $display("FAIL req_hold cyc=%0d req=%b addr=%h required req=1 addr=%h", cyc, req_mem_prog_o, addr_mem_prog_o, prev_req_addr);
      end
    end
    if (prev_stall) begin
      checks++;
      if (fetch_valid_o !== 1'b1 || fetch_addr_o !== prev_faddr || fetch_instr_o !== prev_finstr) begin
        failures++;
        $display("FAIL out_stable cyc=%0d valid=%b addr=%h instr=%h required 1 %h %h", cyc, fetch_valid_o, fetch_addr_o, fetch_instr_o, prev_faddr, prev_finstr);
      end
    end
    if (prev_branch) begin
      checks++;
      if (fetch_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL valid_after_branch cyc=%0d valid=%b required 0", cyc, fetch_valid_o);
      end
    end
    if (req_mem_prog_o && gnt_mem_prog_i) begin
      mq.push_back(addr_mem_prog_o);
      checks++;
      if (mq.size() > MAXO) begin
        failures++;
        $display("FAIL outstanding cyc=%0d count=%0d required <=%0d", cyc, mq.size(), MAXO);
      end
    end
    if (fetch_valid_o && fetch_ready_i && !branch_i) begin
      checks++;
      pops++;
      if (fetch_addr_o !== exp_addr || fetch_instr_o !== memfn(exp_addr[9:0])) begin
        failures++;
        $display("FAIL stream cyc=%0d addr=%h instr=%h required addr=%h instr=%h", cyc, fetch_addr_o, fetch_instr_o, exp_addr, memfn(exp_addr[9:0]));
      end
      if (want_first) begin first_after_br = fetch_addr_o; want_first = 0; end
      if (fetch_addr_o == 32'h0 && prev_pop_addr == 32'hFFFF_FFFC) saw_wrap = 1;
      prev_pop_addr = fetch_addr_o;
      exp_addr      = exp_addr + 32'd4;
    end
    if (branch_i) begin
      exp_addr   = branch_addr_i & ~32'd3;
      want_first = 1;
    end
    prev_hold     = req_mem_prog_o && !gnt_mem_prog_i;
    prev_req_addr = addr_mem_prog_o;
    prev_stall    = fetch_valid_o && !fetch_ready_i && !branch_i;
    prev_faddr    = fetch_addr_o;
    prev_finstr   = fetch_instr_o;
    prev_branch   = branch_i;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({req_mem_prog_o, addr_mem_prog_o, fetch_valid_o, fetch_instr_o, fetch_addr_o} !== {1'b0, 10'h0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_values req=%b addr=%h valid=%b instr=%h faddr=%h required all 0", req_mem_prog_o, addr_mem_prog_o, fetch_valid_o, fetch_instr_o, fetch_addr_o);
    end
    do_reset();
    #1;
    checks++;
    if (req_mem_prog_o !== 1'b0) begin
      failures++;
      $display("FAIL first_req_early req=%b required 0", req_mem_prog_o);
    end
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    inj_rv = 1;
    repeat (6) tick();
    checks++;
    if (pops < 2) begin
      failures++;
      $display("FAIL reset_start pops=%0d required >=2", pops);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (30) tick();
    checks++;
    if (first_rv < 0 || first_v - first_rv != EXP_LAT) begin
      failures++;
      $display("FAIL rvalid_to_valid latency=%0d required %0d", first_v - first_rv, EXP_LAT);
    end
    checks++;
    if (gap != 0) begin
      failures++;
      $display("FAIL throughput gaps=%0d required 0", gap);
    end
    checks++;
    if (pops < 25) begin
      failures++;
      $display("FAIL zero_wait_count pops=%0d required >=25", pops);
    end
  endtask

  task automatic test_fill();
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    repeat (20) tick();
    checks++;
    if (rvs - pops != DEP || mq.size() != 0 || req_mem_prog_o !== 1'b0 || fetch_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL fill buffered=%0d outstanding=%0d req=%b valid=%b required %0d 0 0 1", rvs - pops, mq.size(), req_mem_prog_o, fetch_valid_o, DEP);
    end
    rdy_pct = 100;
    repeat (15) tick();
    checks++;
    if (pops < 10 || exp_addr < 32'h14) begin
      failures++;
      $display("FAIL fill_resume pops=%0d next=%h required >=10 and >=14", pops, exp_addr);
    end
  endtask

  task automatic test_gnt_stall();
    int n;
    do_reset();
    gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
    n = 0;
    do begin tick(); n++; end while (!req_mem_prog_o && n < 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (req_mem_prog_o !== 1'b1 || addr_mem_prog_o !== 10'h0) begin
        failures++;
        $display("FAIL gnt_stall i=%0d req=%b addr=%h required 1 000", i, req_mem_prog_o, addr_mem_prog_o);
      end
    end
    gnt_pct = 100; tick();
    gnt_pct = 0;   tick();
    checks++;
    if (req_mem_prog_o !== 1'b1 || addr_mem_prog_o !== 10'h4) begin
      failures++;
      $display("FAIL after_gnt req=%b addr=%h required 1 004", req_mem_prog_o, addr_mem_prog_o);
    end
    repeat (4) tick();
    checks++;
    if (pops != 1) begin
      failures++;
      $display("FAIL one_word_per_gnt words=%0d required 1", pops);
    end
  endtask

  task automatic test_branch();
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    repeat (3) tick();
    rv_pct = 0;
    repeat (3) tick();
    checks++;
    if (mq.size() != 2 || fetch_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL branch_setup outstanding=%0d valid=%b required 2 1", mq.size(), fetch_valid_o);
    end
    br_now = 1; br_target = 32'h103;
    tick();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (20) tick();
    checks++;
    if (first_after_br !== 32'h100) begin
      failures++;
      $display("FAIL branch_first addr=%h required 00000100", first_after_br);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (3) tick();
    br_now = 1; br_target = 32'hFFFF_FFF8;
    repeat (15) tick();
    checks++;
    if (!saw_wrap) begin
      failures++;
      $display("FAIL wrap seen=%0d required 1", saw_wrap);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_mem_prog_o, addr_mem_prog_o, fetch_valid_o, fetch_instr_o, fetch_addr_o} !== {1'b0, 10'h0, 1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid req=%b addr=%h valid=%b instr=%h faddr=%h required all 0", req_mem_prog_o, addr_mem_prog_o, fetch_valid_o, fetch_instr_o, fetch_addr_o);
    end
    do_reset();
    repeat (20) tick();
    checks++;
    if (pops < 15) begin
      failures++;
      $display("FAIL reset_restart pops=%0d required >=15", pops);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if (i % 250 == 0) begin
        gnt_pct = 30 + int'($urandom_range(70));
        rv_pct  = 30 + int'($urandom_range(70));
        rdy_pct = 20 + int'($urandom_range(80));
      end
      if ($urandom_range(99) < 3) begin
        br_now    = 1;
        br_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      end
      tick();
    end
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (20) tick();
    checks++;
    if (pops < 200) begin
      failures++;
      $display("FAIL random_progress pops=%0d required >=200", pops);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    br_target = 32'h0;
    clear_model();
    test_reset();
    test_zero_wait();
    test_fill();
    test_gnt_stall();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
